seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Holds a 32-bit display word and selects one digit at a time at a programmable scan rate.
- Presents that digit's 4-bit nibble to the downstream hex-to-segment decoder, and drives the one-hot digit-select lines and the per-digit decimal point.
- Updates are double-buffered and take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot (minimum 2); at 100 MHz the default gives 1 kHz per digit, 125 Hz per frame.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
value_in  input  32  new display word; nibble k = value_in[4k+3:4k] drives digit k
load  input  1  one-cycle strobe; captures value_in and dp_in into the shadow registers
dp_in  input  8  decimal-point enables per digit, captured with load
digit_en  input  8  live (unbuffered) per-digit enable mask; 0 keeps that digit dark
nibble_out  output  4  nibble of the currently selected digit, to the segment decoder
digit_sel  output  8  one-hot active-high digit select; all-zero means dark
dp_out  output  1  decimal point for the current digit
frame_done  output  1  one-cycle pulse after digit 7 has been presented
pending  output  1  shadow holds a load not yet applied

Behaviour:
- Reset (rst_n low) acts immediately, independent of clk, including mid-frame:
  - prescaler = 0, idx = 0.
  - active_val = 0, active_dp = 0, shadow registers = 0.
  - nibble_out = 0, digit_sel = 8'h00, dp_out = 0, frame_done = 0, pending = 0.
  - An unapplied load is discarded.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - tick is the internal 1-cycle pulse when the count equals SCAN_DIV-1.
  - The first tick after reset release occurs on the SCAN_DIV-th rising edge.
- On each tick edge, using pre-edge values:
  - nibble_out <= active_val[4*idx+3 : 4*idx].
  - dp_out <= active_dp[idx].
  - digit_sel <= digit_en[idx] ? (8'b1 << idx) : 8'h00.
  - idx <= (idx==7) ? 0 : idx+1.
- Between ticks, all outputs hold their values; each digit is lit for exactly SCAN_DIV cycles.
- Until the first tick after reset, the display is dark.
- Frame wrap is the tick edge on which idx==7. On that edge:
  - frame_done <= 1 for exactly one cycle.
  - If pending: active_val <= shadow_val, active_dp <= shadow_dp, pending <= 0.
  - Digit 7 is still presented with the old active value; digit 0 of the next frame uses the new value.
- Load:
  - On load: shadow_val <= value_in, shadow_dp <= dp_in, pending <= 1.
  - Repeated loads before a wrap overwrite the shadow; the last one wins.
- Simultaneous load and frame wrap on the same edge:
  - active_val <= value_in, active_dp <= dp_in; the bypass takes priority over the old shadow.
  - shadow is updated to the same value; pending stays 0.
- digit_en:
  - Sampled at each tick, not buffered.
  - When digit_en[idx] is 0, nibble_out and dp_out are still updated; only digit_sel is forced to 0.
- Output timing: all outputs are registered; no combinational path from any input to any output.
- digit_sel is never more than one-hot at any cycle.

Test Plan:
- Reset dark state and first tick (SCAN_DIV=4): release rst_n, digit_en=8'hFF, no load -> outputs 0/8'h00 for 3 cycles; on the 4th edge digit_sel=8'h01, nibble_out=0; digit_sel then steps 8'h02, 8'h04 … 8'h80, 8'h01 every 4 cycles.
- Scan order (SCAN_DIV=4): load value_in=32'h76543210, dp_in=8'h05 during frame 0 -> next frame shows nibble_out 0,1,…,7 with digit_sel 8'h01…8'h80; dp_out=1 only on digits 0 and 2; frame_done pulses once per 32 cycles, one cycle wide, after the digit-7 edge.
- Tear-free update: while digit 3 is lit showing 32'h76543210, load 32'hFEDCBA98 -> pending=1; digits 4–7 show 4,5,6,7; at the wrap pending=0 and the next frame shows 8,9,A,B,C,D,E,F.
- Simultaneous load and wrap: assert load with 32'h11111111 on the exact idx==7 tick cycle -> pending stays 0; next digit 0 shows 1. Also issue a second load mid-frame after an earlier one -> only the last value appears.
- Enable mask: digit_en=8'h0F -> digit_sel=8'h00 during slots 4–7 while nibble_out still sequences 4..7; change digit_en mid-frame -> takes effect at the next tick.
- Async reset mid-operation: drop rst_n between clock edges while digit 5 is lit with pending=1 -> all outputs 0 immediately, without waiting for a clock edge; after release no old value is displayed and pending=0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scan controller. It double-buffers the
// display word so that new values are applied only at frame boundaries.
module seg_scan_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value_in,
  input  logic        load,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  output logic [3:0]  nibble_out,
  output logic [7:0]  digit_sel,
  output logic        dp_out,
  output logic        frame_done,
  output logic        pending
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   active_val_q, active_val_d;
  logic [7:0]    active_dp_q, active_dp_d;
  logic [31:0]   shadow_val_q, shadow_val_d;
  logic [7:0]    shadow_dp_q, shadow_dp_d;
  logic          pending_q, pending_d;
  logic [3:0]    nibble_q, nibble_d;
  logic [7:0]    sel_q, sel_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;
  logic          tick, wrap;

  assign tick = (presc_q == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx_q == 3'd7);

  always_comb begin
    presc_d      = tick ? '0 : presc_q + PW'(1);
    idx_d        = idx_q;
    nibble_d     = nibble_q;
    sel_d        = sel_q;
    dp_d         = dp_q;
    frame_done_d = wrap;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;

    if (tick) begin
      nibble_d = active_val_q[idx_q*4 +: 4];
      dp_d     = active_dp_q[idx_q];
      sel_d    = digit_en[idx_q] ? (8'b1 << idx_q) : 8'h00;
      idx_d    = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
    end

    // A load coinciding with the wrap bypasses the shadow straight to active.
    if (wrap) begin
      if (load) begin
        active_val_d = value_in;
        active_dp_d  = dp_in;
      end else if (pending_q) begin
        active_val_d = shadow_val_q;
        active_dp_d  = shadow_dp_q;
      end
      pending_d = 1'b0;
    end

    if (load) begin
      shadow_val_d = value_in;
      shadow_dp_d  = dp_in;
      if (!wrap) pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      nibble_q     <= '0;
      sel_q        <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      nibble_q     <= nibble_d;
      sel_q        <= sel_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nibble_out = nibble_q;
  assign digit_sel  = sel_q;
  assign dp_out     = dp_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed plus random bench for seg_scan_driver; the expected display is derived
// from the edge count since reset (slot = edges / SCAN_DIV).
module tb_seg_scan_driver;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] value_in;
  logic        load;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic [3:0]  nibble_out;
  logic [7:0]  digit_sel;
  logic        dp_out;
  logic        frame_done;
  logic        pending;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load), .dp_in(dp_in),
    .digit_en(digit_en), .nibble_out(nibble_out), .digit_sel(digit_sel),
    .dp_out(dp_out), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference state
  int          m_n;
  int          m_cur;
  logic [31:0] m_act_val, m_shd_val;
  logic [7:0]  m_act_dp, m_shd_dp;
  logic        m_pend;
  logic [3:0]  e_nib;
  logic [7:0]  e_sel;
  logic        e_dp, e_fd;

  task automatic model_reset();
    m_n = 0; m_cur = -1;
    m_act_val = '0; m_shd_val = '0; m_act_dp = '0; m_shd_dp = '0; m_pend = 1'b0;
    e_nib = '0; e_sel = '0; e_dp = 1'b0; e_fd = 1'b0;
  endtask

  function automatic bit next_is_wrap();
    int n1 = m_n + 1;
    return (n1 % SD == 0) && (((n1 / SD) - 1) % 8 == 7);
  endfunction

  task automatic model_edge(input logic ld, input logic [31:0] v, input logic [7:0] dp,
                            input logic [7:0] en);
    bit wrap = 0;
    int d;
    m_n++;
    e_fd = 1'b0;
    if (m_n % SD == 0) begin
      d     = ((m_n / SD) - 1) % 8;
      e_nib = 4'((m_act_val >> (4 * d)) & 32'hF);
      e_dp  = m_act_dp[d];
      e_sel = en[d] ? 8'(1 << d) : 8'h00;
      m_cur = d;
      wrap  = (d == 7);
      e_fd  = wrap;
    end
    if (wrap) begin
      if (ld) begin m_act_val = v; m_act_dp = dp; end
      else if (m_pend) begin m_act_val = m_shd_val; m_act_dp = m_shd_dp; end
      m_pend = 1'b0;
    end
    if (ld) begin
      m_shd_val = v; m_shd_dp = dp;
      if (!wrap) m_pend = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, m_n);
    end
  endtask

  task automatic check_all();
    chk("nibble_out", 32'(nibble_out), 32'(e_nib));
    chk("digit_sel", 32'(digit_sel), 32'(e_sel));
    chk("dp_out", 32'(dp_out), 32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("onehot0", 32'($onehot0(digit_sel)), 32'd1);
  endtask

  // Called at a falling edge: drive, advance the model, clock, check.
  task automatic step(input logic ld, input logic [31:0] v, input logic [7:0] dp,
                      input logic [7:0] en);
    load = ld; value_in = v; dp_in = dp; digit_en = en;
    model_edge(ld, v, dp, en);
    @(posedge clk);
    @(negedge clk);
    check_all();
    load = 1'b0;
  endtask

  task automatic idle(input int k, input logic [7:0] en);
    for (int i = 0; i < k; i++) step(1'b0, 32'h0, 8'h00, en);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value_in = '0; dp_in = '0; digit_en = 8'hFF;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();

    // Dark until first tick, then one digit per SD cycles
    rst_n = 1'b1;
    idle(9, 8'hFF);
    step(1'b1, 32'h7654_3210, 8'h05, 8'hFF);
    idle(60, 8'hFF);

    // Tear-free update while digit 3 is lit
    for (int i = 0; i < 64 && m_cur != 3; i++) step(1'b0, 32'h0, 8'h00, 8'hFF);
    chk("reach_digit3", 32'(m_cur), 32'd3);
    step(1'b1, 32'hFEDC_BA98, 8'hA0, 8'hFF);
    idle(48, 8'hFF);

    // Load on the exact wrap edge
    for (int i = 0; i < 64 && !next_is_wrap(); i++) step(1'b0, 32'h0, 8'h00, 8'hFF);
    chk("reach_wrap", 32'(next_is_wrap()), 32'd1);
    step(1'b1, 32'h1111_1111, 8'hFF, 8'hFF);
    idle(10, 8'hFF);

    // Two loads in one frame: last wins
    step(1'b1, 32'hAAAA_AAAA, 8'h0F, 8'hFF);
    idle(3, 8'hFF);
    step(1'b1, 32'h5A5A_5A5A, 8'h81, 8'hFF);
    idle(60, 8'hFF);

    // Enable mask, then change mid-frame
    idle(40, 8'h0F);
    idle(6, 8'hF0);
    idle(30, 8'hFF);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      logic [7:0] en;
      en = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
      step(($urandom_range(0, 15) == 0), $urandom, 8'($urandom), en);
    end

    // Async reset while digit 5 is lit with a pending load
    for (int i = 0; i < 64 && m_cur != 4; i++) step(1'b0, 32'h0, 8'h00, 8'hFF);
    step(1'b1, 32'h9ABC_DEF0, 8'h3C, 8'hFF);
    for (int i = 0; i < 64 && m_cur != 5; i++) step(1'b0, 32'h0, 8'h00, 8'hFF);
    chk("pre_reset_digit", 32'(digit_sel), 32'h20);
    chk("pre_reset_pending", 32'(pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(40, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
